// File: rtl/rgu_result_fifo.sv
// rgu_result_fifo: result buffer between the RGU output stage and its consumer.
// Circular buffer with registered read data, occupancy counter, combinational
// status flags derived from the counter, and sticky overflow/underflow flags.
// Optional build macro RGU_FIFO_DROP_COUNT_EN: when defined, a saturating
// 16-bit counter of dropped pushes is built; otherwise oDropCount is tied to 0.

module rgu_result_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iFifoPush,
    input  logic [WIDTH-1:0]         iFifoData,
    input  logic                     iPop,
    input  logic                     iClearFlags,
    output logic [WIDTH-1:0]         oData,
    output logic                     oValid,
    output logic                     oEmpty,
    output logic                     oFull,
    output logic                     oAlmostFull,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oOverflow,
    output logic                     oUnderflow,
    output logic [15:0]              oDropCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic push_ok;
    logic pop_ok;
    logic drop;
    logic pop_empty;

    // Status flags come straight from the occupancy counter, no extra latency.
    always_comb begin
        oEmpty      = (oCount == '0);
        oFull       = (oCount == CW'(DEPTH));
        oAlmostFull = (oCount >= CW'(DEPTH - AF_MARGIN));
    end

    // Accept/drop decisions; a full FIFO still takes a push when a pop frees a slot.
    always_comb begin
        pop_ok    = iPop && !oEmpty;
        push_ok   = iFifoPush && (!oFull || iPop);
        drop      = iFifoPush && oFull && !iPop;
        pop_empty = iPop && oEmpty;
    end

    // Storage array; never reset, stale words are unreachable once pointers clear.
    always_ff @(posedge iClock) begin
        if (push_ok) begin
            mem[wr_ptr] <= iFifoData;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            oCount <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   oCount <= oCount + CW'(1);
                2'b01:   oCount <= oCount - CW'(1);
                default: oCount <= oCount;
            endcase
        end
    end

    // Registered read port: load the oldest word on an accepted pop, else hold.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oData  <= '0;
            oValid <= 1'b0;
        end else begin
            oValid <= pop_ok;
            if (pop_ok) begin
                oData <= mem[rd_ptr];
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle wins over the clear.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oOverflow  <= 1'b0;
            oUnderflow <= 1'b0;
        end else begin
            if (drop) begin
                oOverflow <= 1'b1;
            end else if (iClearFlags) begin
                oOverflow <= 1'b0;
            end
            if (pop_empty) begin
                oUnderflow <= 1'b1;
            end else if (iClearFlags) begin
                oUnderflow <= 1'b0;
            end
        end
    end

`ifdef RGU_FIFO_DROP_COUNT_EN
    // Saturating dropped-push counter; a drop during a clear restarts it at 1.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oDropCount <= 16'd0;
        end else if (drop) begin
            if (iClearFlags) begin
                oDropCount <= 16'd1;
            end else if (oDropCount != 16'hFFFF) begin
                oDropCount <= oDropCount + 16'd1;
            end
        end else if (iClearFlags) begin
            oDropCount <= 16'd0;
        end
    end
`else
    assign oDropCount = 16'd0;
`endif

endmodule

// File: tb/tb_rgu_result_fifo.sv
// tb_rgu_result_fifo: directed self-checking bench for rgu_result_fifo
// (WIDTH=32, DEPTH=16, AF_MARGIN=2). Works with or without
// RGU_FIFO_DROP_COUNT_EN defined.

module tb_rgu_result_fifo;

    logic        clk;
    logic        rst;
    logic        push;
    logic [31:0] din;
    logic        pop;
    logic        clr;
    logic [31:0] dout;
    logic        valid;
    logic        empty;
    logic        full;
    logic        afull;
    logic [4:0]  count;
    logic        ovf;
    logic        unf;
    logic [15:0] drops;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] last_data;

`ifdef RGU_FIFO_DROP_COUNT_EN
    localparam logic [15:0] DROP1 = 16'd1;
`else
    localparam logic [15:0] DROP1 = 16'd0;
`endif

    rgu_result_fifo #(.WIDTH(32), .DEPTH(16), .AF_MARGIN(2)) dut (
        .iClock      (clk),
        .iReset      (rst),
        .iFifoPush   (push),
        .iFifoData   (din),
        .iPop        (pop),
        .iClearFlags (clr),
        .oData       (dout),
        .oValid      (valid),
        .oEmpty      (empty),
        .oFull       (full),
        .oAlmostFull (afull),
        .oCount      (count),
        .oOverflow   (ovf),
        .oUnderflow  (unf),
        .oDropCount  (drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the queue model, then check read port and status.
    task automatic step(input bit p, input logic [31:0] d, input bit r, input bit c);
        bit push_acc;
        bit pop_acc;
        push_acc = p && ((q.size() < 16) || r);
        pop_acc  = r && (q.size() > 0);
        if (pop_acc) last_data = q.pop_front();
        if (push_acc) q.push_back(d);
        push = p; din = d; pop = r; clr = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
        check("valid", {31'd0, valid}, {31'd0, pop_acc});
        check("data", dout, last_data);
        check("count", {27'd0, count}, q.size());
        check("afull", {31'd0, afull}, {31'd0, q.size() >= 14});
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; din = '0; pop = 1'b0; clr = 1'b0;
        last_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_afull", {31'd0, afull}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", dout, 32'd0);
        check("rst_flags", {30'd0, ovf, unf}, 32'd0);
        check("rst_drops", {16'd0, drops}, 32'd0);
        rst = 1'b0;

        // basic three-word transfer
        step(1, 32'h0, 0, 0);
        step(1, 32'h40000, 0, 0);
        step(1, 32'h60000, 0, 0);
        check("t36_count3", {27'd0, count}, 32'd3);
        step(0, 0, 1, 0);
        check("t36_d0", dout, 32'h0);
        step(0, 0, 1, 0);
        check("t36_d1", dout, 32'h40000);
        step(0, 0, 1, 0);
        check("t36_d2", dout, 32'h60000);
        check("t36_empty", {31'd0, empty}, 32'd1);
        step(0, 0, 0, 0);
        check("t36_hold", dout, 32'h60000);

        // fill to full, 17th push dropped
        for (int i = 0; i < 16; i++) begin
            step(1, 32'h100 + i, 0, 0);
            if (i == 12) check("t37_af13", {31'd0, afull}, 32'd0);
            if (i == 13) check("t37_af14", {31'd0, afull}, 32'd1);
            if (i == 14) check("t37_notfull15", {31'd0, full}, 32'd0);
        end
        check("t37_full", {31'd0, full}, 32'd1);
        check("t37_noovf", {31'd0, ovf}, 32'd0);
        step(1, 32'hDEAD, 0, 0);
        check("t37_count", {27'd0, count}, 32'd16);
        check("t37_ovf", {31'd0, ovf}, 32'd1);
        check("t37_drops", {16'd0, drops}, {16'd0, DROP1});

        // drop in the same cycle as clear: error wins, count restarts
        step(1, 32'hBEEF, 0, 1);
        check("clr_drop_ovf", {31'd0, ovf}, 32'd1);
        check("clr_drop_cnt", {16'd0, drops}, {16'd0, DROP1});
        step(0, 0, 0, 1);
        check("clr_ovf", {31'd0, ovf}, 32'd0);
        check("clr_drops", {16'd0, drops}, 32'd0);

        // push + pop while full
        step(1, 32'hABCD, 1, 0);
        check("t38_data", dout, 32'h100);
        check("t38_count", {27'd0, count}, 32'd16);
        check("t38_ovf", {31'd0, ovf}, 32'd0);
        check("t38_drops", {16'd0, drops}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 1, 0);
            check("t38_order", dout, 32'h100 + i);
        end
        step(0, 0, 1, 0);
        check("t38_last", dout, 32'hABCD);
        check("t38_empty", {31'd0, empty}, 32'd1);

        // underflow cases
        step(0, 0, 1, 0);
        check("t39_unf", {31'd0, unf}, 32'd1);
        check("t39_hold", dout, 32'hABCD);
        step(0, 0, 0, 1);
        check("t39_clr", {31'd0, unf}, 32'd0);
        step(1, 32'h55, 1, 0);
        check("t39_unf2", {31'd0, unf}, 32'd1);
        check("t39_valid", {31'd0, valid}, 32'd0);
        check("t39_count", {27'd0, count}, 32'd1);
        step(0, 0, 1, 0);
        check("t39_data", dout, 32'h55);

        // interleaved traffic across pointer wrap, almost-full toggling at 13/14
        for (int i = 0; i < 13; i++) step(1, 32'h1000_0000 + i, 0, 0);
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0)      step(1, 32'h2000_0000 + k, 1, 0);
            else if (k % 4 == 1) step(1, 32'h2000_0000 + k, 0, 0);
            else                 step(0, 0, 1, 0);
        end
        check("t40_count", {27'd0, count}, 32'd13);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        check("t41_pre", {27'd0, count}, 32'd5);

        // asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        check("t41_count", {27'd0, count}, 32'd0);
        check("t41_empty", {31'd0, empty}, 32'd1);
        check("t41_valid", {31'd0, valid}, 32'd0);
        check("t41_data", dout, 32'd0);
        check("t41_afull", {31'd0, afull}, 32'd0);
        #1;
        rst = 1'b0;
        q.delete();
        last_data = '0;
        step(1, 32'h77, 0, 0);
        step(0, 0, 1, 0);
        check("t41_readback", dout, 32'h77);
        check("t41_empty2", {31'd0, empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
